// File: rtl/sram_readback_pkg.sv
// Shared SRAM select encoding, readback FSM states and default widths
// used by the host-side SRAM access blocks.
package sram_readback_pkg;

    localparam int DEFAULT_SRAM_DATA_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH      = 8;

    typedef enum logic [1:0] {
        SEL_WEIGHT   = 2'd0,
        SEL_INPUT    = 2'd1,
        SEL_OUTPUT   = 2'd2,
        SEL_RESERVED = 2'd3
    } sram_sel_t;

    typedef enum logic [1:0] {
        RB_IDLE,
        RB_ISSUE,
        RB_DRAIN,
        RB_DONE
    } rb_state_t;

endpackage

// File: rtl/readback_fifo.sv
// Small synchronous FIFO buffering SRAM read data for the host stream.
// Head is read straight from storage; a full FIFO accepts a push when popped.
module readback_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_readback.sv
// Drains an inclusive SRAM address range to the host as a valid/ready stream,
// issuing reads only when FIFO space covers every read still in flight.
module sram_readback
    import sram_readback_pkg::*;
#(
    parameter int SRAM_DATA_WIDTH = DEFAULT_SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int FIFO_DEPTH      = 4,
    parameter int READ_LATENCY    = 1
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_reg_clear,
    input  logic                       i_read_start,
    input  logic [1:0]                 i_sram_select,
    input  logic [ADDR_WIDTH-1:0]      i_start_addr,
    input  logic [ADDR_WIDTH-1:0]      i_end_addr,
    output logic                       o_sram_rd_en,
    output logic [ADDR_WIDTH-1:0]      o_sram_rd_addr,
    output logic [1:0]                 o_sram_rd_sel,
    input  logic [SRAM_DATA_WIDTH-1:0] i_sram_rd_data,
    output logic [SRAM_DATA_WIDTH-1:0] o_data_out,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_V = SUM_W'(FIFO_DEPTH);

    rb_state_t               state;
    rb_state_t               state_next;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   end_addr;
    sram_sel_t               sel;
    logic [READ_LATENCY-1:0] pipe;
    logic [SUM_W-1:0]        inflight;
    logic [SUM_W-1:0]        credit_used;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    rd_en;
    logic                    load;
    logic                    advance;
    logic                    push;
    logic                    pop;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + SUM_W'(pipe[i]);
        end
    end

    assign credit_used = SUM_W'(fifo_count) + inflight;

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        unique case (state)
            RB_IDLE: begin
                if (i_read_start) begin
                    load       = 1'b1;
                    state_next = (i_start_addr > i_end_addr) ? RB_DONE : RB_ISSUE;
                end
            end
            RB_ISSUE: begin
                if ((credit_used < DEPTH_V) && !fifo_full) begin
                    rd_en = 1'b1;
                    // Compare before incrementing so the top address never wraps to 0.
                    if (addr == end_addr) begin
                        state_next = RB_DRAIN;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            RB_DRAIN: begin
                if ((inflight == '0) && fifo_empty) begin
                    state_next = RB_DONE;
                end
            end
            RB_DONE: begin
                state_next = RB_IDLE;
            end
            default: state_next = RB_IDLE;
        endcase
        if (i_reg_clear) begin
            state_next = RB_IDLE;
            rd_en      = 1'b0;
            load       = 1'b0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state    <= RB_IDLE;
            addr     <= '0;
            end_addr <= '0;
            sel      <= SEL_WEIGHT;
            pipe     <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                addr     <= i_start_addr;
                end_addr <= i_end_addr;
                sel      <= sram_sel_t'(i_sram_select);
            end else if (advance) begin
                addr <= addr + ADDR_WIDTH'(1);
            end
            // Clearing the tracker discards any read data still on its way back.
            if (i_reg_clear) begin
                pipe <= '0;
            end else begin
                pipe[0] <= rd_en;
                for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    assign push = pipe[READ_LATENCY-1] && !i_reg_clear;
    assign pop  = o_valid && i_ready;

    readback_fifo #(
        .WIDTH (SRAM_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_nrst),
        .clear     (i_reg_clear),
        .push      (push),
        .push_data (i_sram_rd_data),
        .pop       (pop),
        .pop_data  (o_data_out),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign o_sram_rd_en   = rd_en;
    assign o_sram_rd_addr = addr;
    assign o_sram_rd_sel  = sel;
    assign o_valid        = !fifo_empty;
    assign o_busy         = (state == RB_ISSUE) || (state == RB_DRAIN);
    assign o_done         = (state == RB_DONE);

endmodule

// File: tb/tb_sram_readback.sv
// Randomised bench for sram_readback: SRAM bank model, stream monitor and
// a range-based reference of which words must come back, in which order.
module tb_sram_readback;

    localparam int DW    = 64;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic          i_reg_clear = 1'b0;
    logic          i_read_start = 1'b0;
    logic [1:0]    i_sram_select = '0;
    logic [AW-1:0] i_start_addr = '0;
    logic [AW-1:0] i_end_addr = '0;
    logic          o_sram_rd_en;
    logic [AW-1:0] o_sram_rd_addr;
    logic [1:0]    o_sram_rd_sel;
    logic [DW-1:0] i_sram_rd_data;
    logic [DW-1:0] o_data_out;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic          o_busy;
    logic          o_done;

    int nchecks = 0;
    int nerrors = 0;

    sram_readback #(
        .SRAM_DATA_WIDTH (DW),
        .ADDR_WIDTH      (AW),
        .FIFO_DEPTH      (DEPTH),
        .READ_LATENCY    (LAT)
    ) dut (
        .i_clk          (i_clk),
        .i_nrst         (i_nrst),
        .i_reg_clear    (i_reg_clear),
        .i_read_start   (i_read_start),
        .i_sram_select  (i_sram_select),
        .i_start_addr   (i_start_addr),
        .i_end_addr     (i_end_addr),
        .o_sram_rd_en   (o_sram_rd_en),
        .o_sram_rd_addr (o_sram_rd_addr),
        .o_sram_rd_sel  (o_sram_rd_sel),
        .i_sram_rd_data (i_sram_rd_data),
        .o_data_out     (o_data_out),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Bank model: weight bank holds 0xA0+addr, the others random words.
    logic [DW-1:0] bank [4][256];
    always @(posedge i_clk) begin
        if (o_sram_rd_en) i_sram_rd_data <= bank[o_sram_rd_sel][o_sram_rd_addr];
        else              i_sram_rd_data <= {$urandom, $urandom};
    end

    // 0: always ready, 1: random, 2: toggle then hold low 10 cycles, 3: never ready
    int ready_mode = 0;
    int ph = 0;
    always @(posedge i_clk) begin
        #1;
        ph = ph + 1;
        case (ready_mode)
            0: i_ready = 1'b1;
            1: i_ready = 1'($urandom_range(0, 1));
            2: i_ready = ((ph % 16) < 6) ? ((ph % 2) == 0) : 1'b0;
            default: i_ready = 1'b0;
        endcase
    end

    logic [AW-1:0] strobe_q[$];
    logic [DW-1:0] recv_q[$];
    int            pop_cyc[$];
    int            first_strobe_cyc = -1;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            valid_seen = 0;
    int            stall_viol = 0;
    int            over_viol = 0;
    bit            stalled = 1'b0;
    logic [DW-1:0] stall_data;

    always @(negedge i_clk) begin
        if (o_sram_rd_en) begin
            strobe_q.push_back(o_sram_rd_addr);
            if (strobe_q.size() == 1) first_strobe_cyc = cyc;
        end
        if (o_valid && i_ready) begin
            recv_q.push_back(o_data_out);
            pop_cyc.push_back(cyc);
        end
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (o_valid) valid_seen = valid_seen + 1;
        if (stalled && o_valid && (o_data_out !== stall_data)) stall_viol = stall_viol + 1;
        stalled    = i_nrst && o_valid && !i_ready;
        stall_data = o_data_out;
        if (strobe_q.size() - recv_q.size() > DEPTH) over_viol = over_viol + 1;
    end

    task automatic clear_mon();
        strobe_q.delete();
        recv_q.delete();
        pop_cyc.delete();
        first_strobe_cyc = -1;
        done_cnt   = 0;
        done_cyc   = -1;
        valid_seen = 0;
        stall_viol = 0;
        over_viol  = 0;
    endtask

    task automatic do_transfer(input logic [AW-1:0] s, input logic [AW-1:0] e,
                               input logic [1:0] sel, input int budget,
                               output bit timeout, output int start_cyc);
        @(posedge i_clk); #1;
        i_start_addr  = s;
        i_end_addr    = e;
        i_sram_select = sel;
        i_read_start  = 1'b1;
        start_cyc     = cyc;
        @(posedge i_clk); #1;
        i_read_start = 1'b0;
        timeout = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (done_cnt > 0) begin
                timeout = 1'b0;
                break;
            end
            @(posedge i_clk);
        end
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        repeat (3) @(negedge i_clk);
        nchecks++; if (o_valid !== 1'b0) begin nerrors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        nchecks++; if (o_busy !== 1'b0) begin nerrors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        nchecks++; if (o_done !== 1'b0) begin nerrors++; $display("FAIL reset_done got %b want 0", o_done); end
        nchecks++; if (o_sram_rd_en !== 1'b0) begin nerrors++; $display("FAIL reset_rd_en got %b want 0", o_sram_rd_en); end
        nchecks++; if ({o_sram_rd_addr, o_sram_rd_sel} !== '0) begin nerrors++; $display("FAIL reset_addr_sel got %h/%h want 0/0", o_sram_rd_addr, o_sram_rd_sel); end
        nchecks++; if (o_data_out !== '0) begin nerrors++; $display("FAIL reset_data got %h want 0", o_data_out); end
        @(posedge i_clk); #1;
        i_nrst = 1'b1;
        repeat (2) @(posedge i_clk);
    endtask

    task automatic test_full_burst();
        bit to; int sc;
        ready_mode = 0;
        clear_mon();
        do_transfer(8'd0, 8'd8, 2'd0, 100, to, sc);
        nchecks++; if (to) begin nerrors++; $display("FAIL burst_timeout got no done want done"); end
        nchecks++; if (recv_q.size() != 9) begin nerrors++; $display("FAIL burst_count got %0d want 9", recv_q.size()); end
        for (int a = 0; a < 9 && a < recv_q.size(); a++) begin
            nchecks++;
            if (recv_q[a] !== 64'hA0 + 64'(a)) begin nerrors++; $display("FAIL burst_word%0d got %h want %h", a, recv_q[a], 64'hA0 + 64'(a)); end
        end
        if (pop_cyc.size() == 9) begin
            nchecks++;
            if (pop_cyc[0] - first_strobe_cyc != LAT + 1) begin nerrors++; $display("FAIL burst_latency got %0d want %0d", pop_cyc[0] - first_strobe_cyc, LAT + 1); end
            nchecks++;
            if (pop_cyc[8] - pop_cyc[0] != 8) begin nerrors++; $display("FAIL burst_throughput got span %0d want 8", pop_cyc[8] - pop_cyc[0]); end
            nchecks++;
            if (done_cyc <= pop_cyc[8]) begin nerrors++; $display("FAIL burst_done_order got done %0d last pop %0d", done_cyc, pop_cyc[8]); end
        end
        nchecks++; if (done_cnt != 1) begin nerrors++; $display("FAIL burst_done_count got %0d want 1", done_cnt); end
        nchecks++; if (o_busy !== 1'b0) begin nerrors++; $display("FAIL burst_busy_after got %b want 0", o_busy); end
    endtask

    task automatic test_backpressure();
        bit to; int sc;
        ready_mode = 2;
        clear_mon();
        do_transfer(8'd2, 8'd7, 2'd0, 300, to, sc);
        nchecks++; if (to) begin nerrors++; $display("FAIL bp_timeout got no done want done"); end
        nchecks++; if (recv_q.size() != 6) begin nerrors++; $display("FAIL bp_count got %0d want 6", recv_q.size()); end
        for (int a = 2; a <= 7 && (a - 2) < recv_q.size(); a++) begin
            nchecks++;
            if (recv_q[a-2] !== 64'hA0 + 64'(a)) begin nerrors++; $display("FAIL bp_word%0d got %h want %h", a, recv_q[a-2], 64'hA0 + 64'(a)); end
        end
        nchecks++; if (over_viol != 0) begin nerrors++; $display("FAIL bp_outstanding got %0d violations want 0", over_viol); end
        nchecks++; if (stall_viol != 0) begin nerrors++; $display("FAIL bp_stable got %0d changes want 0", stall_viol); end
        ready_mode = 0;
    endtask

    task automatic test_single_and_empty();
        bit to; int sc;
        ready_mode = 0;
        clear_mon();
        do_transfer(8'd5, 8'd5, 2'd0, 50, to, sc);
        nchecks++; if (to || done_cnt != 1) begin nerrors++; $display("FAIL single_done got %0d want 1", done_cnt); end
        nchecks++; if (recv_q.size() != 1) begin nerrors++; $display("FAIL single_count got %0d want 1", recv_q.size()); end
        else begin
            nchecks++; if (recv_q[0] !== 64'hA5) begin nerrors++; $display("FAIL single_word got %h want a5", recv_q[0]); end
        end
        clear_mon();
        do_transfer(8'd6, 8'd3, 2'd0, 20, to, sc);
        nchecks++; if (to || done_cnt != 1) begin nerrors++; $display("FAIL empty_done got %0d want 1", done_cnt); end
        nchecks++; if (valid_seen != 0 || strobe_q.size() != 0) begin nerrors++; $display("FAIL empty_activity got valid %0d strobes %0d want 0 0", valid_seen, strobe_q.size()); end
        nchecks++; if (done_cyc - sc < 1 || done_cyc - sc > 2) begin nerrors++; $display("FAIL empty_done_latency got %0d want 1..2", done_cyc - sc); end
    endtask

    task automatic test_top_range();
        bit to; int sc;
        ready_mode = 0;
        clear_mon();
        do_transfer(8'hFD, 8'hFF, 2'd0, 50, to, sc);
        repeat (5) @(posedge i_clk);
        nchecks++; if (to) begin nerrors++; $display("FAIL top_timeout got no done want done"); end
        nchecks++; if (strobe_q.size() != 3) begin nerrors++; $display("FAIL top_strobes got %0d want 3", strobe_q.size()); end
        for (int k = 0; k < strobe_q.size() && k < 3; k++) begin
            nchecks++;
            if (strobe_q[k] !== 8'(8'hFD + k)) begin nerrors++; $display("FAIL top_addr%0d got %h want %h", k, strobe_q[k], 8'(8'hFD + k)); end
        end
        nchecks++; if (recv_q.size() != 3) begin nerrors++; $display("FAIL top_count got %0d want 3", recv_q.size()); end
        for (int k = 0; k < recv_q.size() && k < 3; k++) begin
            nchecks++;
            if (recv_q[k] !== 64'hA0 + 64'hFD + 64'(k)) begin nerrors++; $display("FAIL top_word%0d got %h want %h", k, recv_q[k], 64'hA0 + 64'hFD + 64'(k)); end
        end
    endtask

    task automatic test_abort();
        bit to; int sc; bit got;
        ready_mode = 3;
        clear_mon();
        @(posedge i_clk); #1;
        i_start_addr = 8'd0; i_end_addr = 8'd8; i_sram_select = 2'd0; i_read_start = 1'b1;
        @(posedge i_clk); #1;
        i_read_start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge i_clk);
            if (strobe_q.size() >= 3) begin got = 1'b1; break; end
        end
        nchecks++; if (!got) begin nerrors++; $display("FAIL abort_strobes got %0d want >=3", strobe_q.size()); end
        #1 i_reg_clear = 1'b1;
        @(posedge i_clk); #1;
        i_reg_clear = 1'b0;
        nchecks++; if (o_valid !== 1'b0) begin nerrors++; $display("FAIL abort_valid got %b want 0", o_valid); end
        nchecks++; if (o_busy !== 1'b0) begin nerrors++; $display("FAIL abort_busy got %b want 0", o_busy); end
        repeat (6) @(posedge i_clk);
        nchecks++; if (done_cnt != 0 || valid_seen == 0) begin nerrors++; $display("FAIL abort_done got %0d dones %0d valids want 0 and >0", done_cnt, valid_seen); end
        ready_mode = 0;
        clear_mon();
        do_transfer(8'd0, 8'd1, 2'd0, 50, to, sc);
        nchecks++; if (recv_q.size() != 2) begin nerrors++; $display("FAIL abort_follow_count got %0d want 2", recv_q.size()); end
        for (int k = 0; k < recv_q.size() && k < 2; k++) begin
            nchecks++;
            if (recv_q[k] !== 64'hA0 + 64'(k)) begin nerrors++; $display("FAIL abort_follow_word%0d got %h want %h", k, recv_q[k], 64'hA0 + 64'(k)); end
        end
    endtask

    task automatic test_busy_restart();
        bit got;
        ready_mode = 1;
        clear_mon();
        @(posedge i_clk); #1;
        i_start_addr = 8'd0; i_end_addr = 8'd8; i_sram_select = 2'd0; i_read_start = 1'b1;
        @(posedge i_clk); #1;
        i_read_start = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_start_addr = 8'd20; i_end_addr = 8'd30; i_sram_select = 2'd1; i_read_start = 1'b1;
        @(posedge i_clk); #1;
        i_read_start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done_cnt > 0) begin got = 1'b1; break; end
            @(posedge i_clk);
        end
        repeat (4) @(posedge i_clk);
        nchecks++; if (!got || done_cnt != 1) begin nerrors++; $display("FAIL restart_done got %0d want 1", done_cnt); end
        nchecks++; if (recv_q.size() != 9 || strobe_q.size() != 9) begin nerrors++; $display("FAIL restart_count got %0d words %0d strobes want 9 9", recv_q.size(), strobe_q.size()); end
        for (int a = 0; a < recv_q.size() && a < 9; a++) begin
            nchecks++;
            if (recv_q[a] !== 64'hA0 + 64'(a)) begin nerrors++; $display("FAIL restart_word%0d got %h want %h", a, recv_q[a], 64'hA0 + 64'(a)); end
        end
        nchecks++; if (stall_viol != 0) begin nerrors++; $display("FAIL restart_stable got %0d changes want 0", stall_viol); end
        ready_mode = 0;
    endtask

    task automatic test_async_reset();
        bit got;
        ready_mode = 3;
        clear_mon();
        @(posedge i_clk); #1;
        i_start_addr = 8'd0; i_end_addr = 8'd2; i_sram_select = 2'd2; i_read_start = 1'b1;
        @(posedge i_clk); #1;
        i_read_start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge i_clk);
            if (strobe_q.size() >= 3) begin got = 1'b1; break; end
        end
        repeat (2) @(posedge i_clk);
        nchecks++; if (!got || o_busy !== 1'b1 || o_valid !== 1'b1) begin nerrors++; $display("FAIL arst_pre got busy %b valid %b want 1 1", o_busy, o_valid); end
        #2 i_nrst = 1'b0;
        #1;
        nchecks++; if ({o_valid, o_busy, o_done, o_sram_rd_en} !== 4'b0) begin nerrors++; $display("FAIL arst_flags got %b want 0000", {o_valid, o_busy, o_done, o_sram_rd_en}); end
        nchecks++; if ({o_sram_rd_addr, o_sram_rd_sel} !== '0 || o_data_out !== '0) begin nerrors++; $display("FAIL arst_buses got %h/%h/%h want 0", o_sram_rd_addr, o_sram_rd_sel, o_data_out); end
        @(posedge i_clk); #1;
        i_nrst = 1'b1;
        ready_mode = 0;
        repeat (3) @(posedge i_clk);
        nchecks++; if (done_cnt != 0) begin nerrors++; $display("FAIL arst_no_done got %0d want 0", done_cnt); end
    endtask

    task automatic test_random();
        bit to; int sc;
        logic [AW-1:0] s, e;
        logic [1:0] sel;
        int expn;
        ready_mode = 1;
        for (int it = 0; it < 10; it++) begin
            sel = 2'($urandom_range(0, 3));
            s   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0 && s != 0) e = 8'($urandom_range(0, int'(s) - 1));
            else e = 8'((int'(s) + $urandom_range(0, 15) > 255) ? 255 : int'(s) + $urandom_range(0, 15));
            expn = (e >= s) ? int'(e) - int'(s) + 1 : 0;
            clear_mon();
            do_transfer(s, e, sel, 400, to, sc);
            nchecks++; if (to || done_cnt != 1) begin nerrors++; $display("FAIL rand%0d_done got %0d want 1", it, done_cnt); end
            nchecks++; if (recv_q.size() != expn) begin nerrors++; $display("FAIL rand%0d_count got %0d want %0d", it, recv_q.size(), expn); end
            if (sel != 2'd3) begin
                for (int k = 0; k < recv_q.size() && k < expn; k++) begin
                    nchecks++;
                    if (recv_q[k] !== bank[sel][8'(int'(s) + k)]) begin nerrors++; $display("FAIL rand%0d_word%0d got %h want %h", it, k, recv_q[k], bank[sel][8'(int'(s) + k)]); end
                end
            end
            nchecks++; if (over_viol != 0 || stall_viol != 0) begin nerrors++; $display("FAIL rand%0d_protocol got %0d/%0d violations want 0/0", it, over_viol, stall_viol); end
        end
        ready_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            bank[0][a] = 64'hA0 + 64'(a);
            bank[1][a] = {$urandom, $urandom};
            bank[2][a] = {$urandom, $urandom};
            bank[3][a] = {$urandom, $urandom};
        end
        test_reset();
        test_full_burst();
        test_backpressure();
        test_single_and_empty();
        test_top_range();
        test_abort();
        test_busy_restart();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
